// File: rtl/lpgbt_ic_pkg.sv
// Shared constants and frame-state encoding for the lpGBT IC downlink transmitter.
// Pure declarations, no timing.
package lpgbt_ic_pkg;

  localparam logic [7:0] HDLC_FLAG  = 8'h7E;
  localparam logic [7:0] ABORT_BYTE = 8'hFF;
  localparam int         HDR_BYTES  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_PARITY,
    ST_CLOSE,
    ST_ABORT
  } ic_state_t;

endpackage

// File: rtl/lpgbt_ic_tx_if.sv
// Command, write-data and IC line bundle between the control logic and the IC transmitter.
// Master drives commands and write bytes; slave is the transmitter.
interface lpgbt_ic_tx_if;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_read_i;
  logic [6:0]  cmd_chip_addr_i;
  logic [15:0] cmd_reg_addr_i;
  logic [15:0] cmd_nwords_i;
  logic [7:0]  wdata_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic [1:0]  ic_o;
  logic        busy_o;
  logic        done_o;
  logic        underrun_o;
  logic        err_len_o;

  modport master (
    output cmd_valid_i, cmd_read_i, cmd_chip_addr_i, cmd_reg_addr_i, cmd_nwords_i,
    output wdata_i, wdata_valid_i,
    input  cmd_ready_o, wdata_ready_o, ic_o, busy_o, done_o, underrun_o, err_len_o
  );

  modport slave (
    input  cmd_valid_i, cmd_read_i, cmd_chip_addr_i, cmd_reg_addr_i, cmd_nwords_i,
    input  wdata_i, wdata_valid_i,
    output cmd_ready_o, wdata_ready_o, ic_o, busy_o, done_o, underrun_o, err_len_o
  );

endinterface

// File: rtl/lpgbt_ic_hdlc_serializer.sv
// Byte-to-2-bit serializer with HDLC zero insertion; pulls a new byte (byte_req) the cycle the
// previous one runs out, so bytes may straddle cycles. ic is registered, one cycle after the load.
module lpgbt_ic_hdlc_serializer (
  input  logic       clk40_i,
  input  logic       aresetn_i,
  input  logic [7:0] byte_dat,
  input  logic       byte_stuff,
  output logic       byte_req,
  output logic [1:0] ic
);

  logic [7:0] sh, sh_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] ones, ones_n;
  logic       sten, sten_n;
  logic [1:0] bits;

  // Two bit slots per cycle; a pending stuffed zero takes priority over fetching a new byte.
  always_comb begin
    sh_n     = sh;
    cnt_n    = cnt;
    ones_n   = ones;
    sten_n   = sten;
    byte_req = 1'b0;
    bits     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sten_n && ones_n == 3'd5) begin
        bits[i] = 1'b0;
        ones_n  = 3'd0;
      end else begin
        if (cnt_n == 4'd0) begin
          sh_n     = byte_dat;
          cnt_n    = 4'd8;
          sten_n   = byte_stuff;
          byte_req = 1'b1;
        end
        bits[i] = sh_n[0];
        sh_n    = {1'b0, sh_n[7:1]};
        cnt_n   = cnt_n - 4'd1;
        ones_n  = (sten_n && bits[i]) ? ones_n + 3'd1 : 3'd0;
      end
    end
  end

  always_ff @(posedge clk40_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sh   <= 8'h00;
      cnt  <= 4'd0;
      ones <= 3'd0;
      sten <= 1'b0;
      ic   <= 2'b00;
    end else begin
      sh   <= sh_n;
      cnt  <= cnt_n;
      ones <= ones_n;
      sten <= sten_n;
      ic   <= bits;
    end
  end

endmodule

// File: rtl/lpgbt_ic_tx.sv
// lpGBT IC downlink transmitter: frames read/write commands as HDLC with parity, 2 bits per frame.
// Command accepted only in IDLE; write bytes are pulled when their slot loads, a missing byte aborts.
module lpgbt_ic_tx
  import lpgbt_ic_pkg::*;
#(
  parameter int          MAX_WORDS = 511,
  parameter logic [7:0]  CMD_BYTE  = 8'h00
) (
  input  logic           clk40_i,
  input  logic           aresetn_i,
  lpgbt_ic_tx_if.slave   bus
);

  ic_state_t   state, state_n;
  logic [2:0]  hdr_idx;
  logic [15:0] word_cnt, nwords_q, reg_q;
  logic [6:0]  chip_q;
  logic        read_q, close_sent, done_q, underrun_q, err_q;
  logic [7:0]  parity, byte_dat;
  logic        byte_stuff, byte_req, accept, len_bad, fetch_ok, fetch_miss, par_upd;

  assign accept     = bus.cmd_valid_i && (state == ST_IDLE);
  assign len_bad    = (bus.cmd_nwords_i == 16'd0) || (bus.cmd_nwords_i > 16'(MAX_WORDS));
  assign fetch_ok   = byte_req && (state == ST_DATA) && bus.wdata_valid_i;
  assign fetch_miss = byte_req && (state == ST_DATA) && !bus.wdata_valid_i;
  // The address byte is outside the parity.
  assign par_upd    = fetch_ok || (byte_req && (state == ST_HDR) && (hdr_idx != 3'd0));

  assign bus.cmd_ready_o   = (state == ST_IDLE);
  assign bus.wdata_ready_o = fetch_ok;
  assign bus.busy_o        = (state != ST_IDLE);
  assign bus.done_o        = done_q;
  assign bus.underrun_o    = underrun_q;
  assign bus.err_len_o     = err_q;

  always_comb begin
    state_n    = state;
    byte_dat   = HDLC_FLAG;
    byte_stuff = 1'b0;
    case (state)
      ST_IDLE: if (accept && !len_bad) state_n = ST_HDR;
      ST_HDR: begin
        byte_stuff = 1'b1;
        case (hdr_idx)
          3'd0:    byte_dat = {chip_q, read_q};
          3'd1:    byte_dat = CMD_BYTE;
          3'd2:    byte_dat = nwords_q[7:0];
          3'd3:    byte_dat = nwords_q[15:8];
          3'd4:    byte_dat = reg_q[7:0];
          default: byte_dat = reg_q[15:8];
        endcase
        if (byte_req && hdr_idx == 3'(HDR_BYTES - 1)) state_n = read_q ? ST_PARITY : ST_DATA;
      end
      ST_DATA: begin
        if (bus.wdata_valid_i) begin
          byte_dat   = bus.wdata_i;
          byte_stuff = 1'b1;
          if (byte_req && word_cnt == nwords_q - 16'd1) state_n = ST_PARITY;
        end else begin
          byte_dat = ABORT_BYTE;
          if (byte_req) state_n = ST_ABORT;
        end
      end
      ST_PARITY: begin
        byte_dat   = parity;
        byte_stuff = 1'b1;
        if (byte_req) state_n = ST_CLOSE;
      end
      // First load here is the closing flag; the next load is an idle flag.
      ST_CLOSE: if (byte_req && close_sent) state_n = ST_IDLE;
      ST_ABORT: if (byte_req) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk40_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state      <= ST_IDLE;
      hdr_idx    <= 3'd0;
      word_cnt   <= 16'd0;
      nwords_q   <= 16'd0;
      reg_q      <= 16'd0;
      chip_q     <= 7'd0;
      read_q     <= 1'b0;
      parity     <= 8'h00;
      close_sent <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      done_q     <= byte_req && (state == ST_CLOSE) && !close_sent;
      underrun_q <= fetch_miss;
      err_q      <= accept && len_bad;
      if (accept) begin
        chip_q     <= bus.cmd_chip_addr_i;
        read_q     <= bus.cmd_read_i;
        reg_q      <= bus.cmd_reg_addr_i;
        nwords_q   <= bus.cmd_nwords_i;
        hdr_idx    <= 3'd0;
        word_cnt   <= 16'd0;
        parity     <= 8'h00;
        close_sent <= 1'b0;
      end
      if (byte_req && state == ST_HDR) hdr_idx <= hdr_idx + 3'd1;
      if (fetch_ok) word_cnt <= word_cnt + 16'd1;
      if (par_upd) parity <= parity ^ byte_dat;
      if (byte_req && state == ST_CLOSE) close_sent <= 1'b1;
    end
  end

  lpgbt_ic_hdlc_serializer u_ser (
    .clk40_i    (clk40_i),
    .aresetn_i  (aresetn_i),
    .byte_dat   (byte_dat),
    .byte_stuff (byte_stuff),
    .byte_req   (byte_req),
    .ic         (bus.ic_o)
  );

endmodule

// File: tb/tb_lpgbt_ic_tx.sv
// Directed bench for lpgbt_ic_tx: an HDLC line decoder rebuilds frames from ic_o and they are
// scored against expected byte sequences queued when each command is issued.
module tb_lpgbt_ic_tx;

  localparam logic [7:0] CMD_BYTE = 8'h00;

  logic clk40;
  logic aresetn;

  lpgbt_ic_tx_if bus ();

  lpgbt_ic_tx #(.MAX_WORDS(511), .CMD_BYTE(CMD_BYTE)) dut (
    .clk40_i   (clk40),
    .aresetn_i (aresetn),
    .bus       (bus)
  );

  initial clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  // Decoder state, written only by the decoder process.
  bit        dbits[$];
  bit [7:0]  dec_bytes[$];
  int        dec_len[$];
  bit [7:0]  raw;
  int        ones, stuff_cnt, abort_cnt;
  bit        aborted;
  int        rdy_cnt, done_cnt, und_cnt, err_cnt;

  // Scoreboard and bookkeeping, written only by the stimulus process.
  bit [7:0]  exp_q[$];
  int        exp_len[$];
  int        frame_rd, byte_rd;
  int        n_checks, n_fail;

  task automatic dec_bit(input bit b);
    int       n;
    bit [7:0] v;
    raw = {b, raw[7:1]};
    if (!b && ones == 5) stuff_cnt++;
    else dbits.push_back(b);
    ones = b ? ones + 1 : 0;
    if (ones == 7) begin
      abort_cnt++;
      aborted = 1'b1;
    end
    if (raw == 8'h7E) begin
      n = dbits.size() - 8;
      if (aborted) dec_len.push_back(-1);
      else if (n > 0) begin
        if (n % 8 != 0) dec_len.push_back(-2);
        else begin
          dec_len.push_back(n / 8);
          for (int j = 0; j < n / 8; j++) begin
            for (int i = 0; i < 8; i++) v[i] = dbits[j * 8 + i];
            dec_bytes.push_back(v);
          end
        end
      end
      dbits.delete();
      aborted = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk40);
      if (!aresetn) begin
        ones = 0;
        raw = 8'h00;
        dbits.delete();
        aborted = 1'b0;
      end else begin
        if (bus.wdata_ready_o) rdy_cnt++;
        if (bus.done_o) done_cnt++;
        if (bus.underrun_o) und_cnt++;
        if (bus.err_len_o) err_cnt++;
        for (int k = 0; k < 2; k++) dec_bit(bus.ic_o[k]);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_seq();
    int seq[4] = '{2, 3, 3, 1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk40);
      check("idle_flag_pair", bus.ic_o, seq[i % 4]);
    end
  endtask

  task automatic send_cmd(input bit rd, input logic [6:0] chip, input logic [15:0] rg,
                          input logic [15:0] nw);
    @(negedge clk40);
    bus.cmd_read_i      = rd;
    bus.cmd_chip_addr_i = chip;
    bus.cmd_reg_addr_i  = rg;
    bus.cmd_nwords_i    = nw;
    bus.cmd_valid_i     = 1'b1;
    check("cmd_ready_before_accept", bus.cmd_ready_o, 1);
    @(posedge clk40);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic expect_frame(input bit rd, input logic [6:0] chip, input logic [15:0] rg,
                              input logic [15:0] nw, input logic [7:0] d0, input logic [7:0] d1);
    bit [7:0] b[$];
    bit [7:0] par;
    b.push_back({chip, rd});
    b.push_back(CMD_BYTE);
    b.push_back(nw[7:0]);
    b.push_back(nw[15:8]);
    b.push_back(rg[7:0]);
    b.push_back(rg[15:8]);
    if (!rd) for (int i = 0; i < int'(nw); i++) b.push_back(i == 0 ? d0 : d1);
    par = 8'h00;
    for (int i = 1; i < b.size(); i++) par ^= b[i];
    b.push_back(par);
    exp_len.push_back(b.size());
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic feed(input logic [7:0] d);
    bit got;
    got = 1'b0;
    bus.wdata_i       = d;
    bus.wdata_valid_i = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk40);
      got = bus.wdata_ready_o;
    end
    check("wdata_fetch_seen", got, 1);
    @(posedge clk40);
    #1;
    bus.wdata_valid_i = 1'b0;
  endtask

  task automatic check_frame();
    int       l, e;
    bit [7:0] eb;
    for (int k = 0; k < 3000 && dec_len.size() <= frame_rd; k++) @(negedge clk40);
    check("frame_seen", int'(dec_len.size() > frame_rd), 1);
    if (dec_len.size() <= frame_rd) return;
    l = dec_len[frame_rd];
    frame_rd++;
    e = (exp_len.size() > 0) ? exp_len.pop_front() : -99;
    check("frame_len", l, e);
    for (int i = 0; i < e; i++) begin
      eb = exp_q.pop_front();
      if (l == e) check("frame_byte", dec_bytes[byte_rd + i], eb);
    end
    if (l > 0) byte_rd += l;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk40);
  endtask

  initial begin
    int r0, d0, u0, e0, a0, s0, f0;
    aresetn             = 1'b0;
    bus.cmd_valid_i     = 1'b0;
    bus.cmd_read_i      = 1'b0;
    bus.cmd_chip_addr_i = 7'd0;
    bus.cmd_reg_addr_i  = 16'd0;
    bus.cmd_nwords_i    = 16'd0;
    bus.wdata_i         = 8'h00;
    bus.wdata_valid_i   = 1'b0;

    // Reset state and idle flag stream
    settle(3);
    check("rst_ic", bus.ic_o, 0);
    check("rst_cmd_ready", bus.cmd_ready_o, 1);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_underrun", bus.underrun_o, 0);
    check("rst_err_len", bus.err_len_o, 0);
    check("rst_wdata_ready", bus.wdata_ready_o, 0);
    #1 aresetn = 1'b1;
    check_idle_seq();

    // Single-byte write
    r0 = rdy_cnt; d0 = done_cnt; a0 = abort_cnt;
    expect_frame(1'b0, 7'h70, 16'h0123, 16'd1, 8'h5A, 8'h00);
    send_cmd(1'b0, 7'h70, 16'h0123, 16'd1);
    check("busy_after_accept", bus.busy_o, 1);
    check("cmd_ready_low_busy", bus.cmd_ready_o, 0);
    feed(8'h5A);
    check_frame();
    settle(6);
    check("wr_ready_pulses", rdy_cnt - r0, 1);
    check("wr_done_pulses", done_cnt - d0, 1);
    check("wr_busy_end", bus.busy_o, 0);
    check("wr_cmd_ready_end", bus.cmd_ready_o, 1);
    check("wr_no_abort", abort_cnt - a0, 0);

    // Stuffing-heavy write
    s0 = stuff_cnt; a0 = abort_cnt; d0 = done_cnt;
    expect_frame(1'b0, 7'h70, 16'hFFFF, 16'd2, 8'hFF, 8'hFF);
    send_cmd(1'b0, 7'h70, 16'hFFFF, 16'd2);
    feed(8'hFF);
    feed(8'hFF);
    check_frame();
    settle(6);
    check("stuff_zeros_seen", int'(stuff_cnt - s0 >= 6), 1);
    check("stuff_no_six_run", abort_cnt - a0, 0);
    check("stuff_done", done_cnt - d0, 1);

    // Read: no data bytes, no fetches
    r0 = rdy_cnt; d0 = done_cnt;
    expect_frame(1'b1, 7'h70, 16'h0010, 16'd4, 8'h00, 8'h00);
    send_cmd(1'b1, 7'h70, 16'h0010, 16'd4);
    check_frame();
    settle(6);
    check("rd_no_wdata_ready", rdy_cnt - r0, 0);
    check("rd_done", done_cnt - d0, 1);

    // Underrun: 3 words requested, 2 supplied
    r0 = rdy_cnt; d0 = done_cnt; u0 = und_cnt; a0 = abort_cnt;
    exp_len.push_back(-1);
    send_cmd(1'b0, 7'h70, 16'h0040, 16'd3);
    feed(8'h11);
    feed(8'h22);
    for (int k = 0; k < 200 && und_cnt == u0; k++) @(negedge clk40);
    check("ur_underrun_pulse", und_cnt - u0, 1);
    check_frame();
    settle(8);
    check("ur_abort_seen", abort_cnt - a0, 1);
    check("ur_ready_pulses", rdy_cnt - r0, 2);
    check("ur_no_done", done_cnt - d0, 0);
    check("ur_cmd_ready", bus.cmd_ready_o, 1);
    check("ur_busy", bus.busy_o, 0);

    // Illegal lengths: 0 and above MAX_WORDS
    e0 = err_cnt; f0 = dec_len.size(); a0 = abort_cnt;
    send_cmd(1'b0, 7'h70, 16'h0000, 16'd0);
    check("len0_err_pulse", bus.err_len_o, 1);
    check("len0_busy", bus.busy_o, 0);
    settle(2);
    check("len0_err_single", bus.err_len_o, 0);
    send_cmd(1'b1, 7'h70, 16'h0000, 16'd512);
    check("len512_err_pulse", bus.err_len_o, 1);
    settle(40);
    check("len_err_count", err_cnt - e0, 2);
    check("len_no_frame", int'(dec_len.size()) - f0, 0);
    check("len_no_abort", abort_cnt - a0, 0);
    check("len_cmd_ready", bus.cmd_ready_o, 1);

    // Reset in the middle of DATA
    send_cmd(1'b0, 7'h70, 16'h0200, 16'd3);
    feed(8'hAA);
    @(negedge clk40);
    #1 aresetn = 1'b0;
    #1;
    check("midrst_ic", bus.ic_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_cmd_ready", bus.cmd_ready_o, 1);
    settle(2);
    #1 aresetn = 1'b1;
    check_idle_seq();
    settle(20);

    check("no_pending_expected", exp_len.size(), 0);
    check("no_unexpected_frames", int'(dec_len.size()) - frame_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
